// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with branch resolution, halt and misaligned-target trap
module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100),
    parameter logic [6:0]       HALT_OPCODE  = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [WIDTH-1:0] imm,
    input  logic             resume,
    input  logic             trap_ack,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] link_addr,
    output logic             taken,
    output logic             halted,
    output logic             trap_pending,
    output logic [WIDTH-1:0] epc
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_TRAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] jalr_sum;
    logic [WIDTH-1:0] target;
    logic             cond;
    logic             want_redirect;
    logic             is_halt;
    logic             misaligned;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign jalr_sum = rs1_val + imm;
    assign target   = (opcode == OP_JALR) ? {jalr_sum[WIDTH-1:1], 1'b0} : (pc_q + imm);
    assign misaligned = (target[1:0] != 2'b00);
    assign is_halt  = (opcode == HALT_OPCODE);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (rs1_val == rs2_val);
            3'b001:  cond = (rs1_val != rs2_val);
            3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  cond = (rs1_val <  rs2_val);
            3'b111:  cond = (rs1_val >= rs2_val);
            default: cond = 1'b0;
        endcase
    end

    // Halt takes priority, so a redirect is never reported on the halt instruction itself.
    assign want_redirect = ((opcode == OP_BRANCH) && cond) || (opcode == OP_JAL) || (opcode == OP_JALR);
    assign taken = (state_q == ST_RUN) && !stall && !is_halt && want_redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (is_halt)                 state_d = ST_HALT;
                    else if (taken && misaligned) state_d = ST_TRAP;
                end
            end
            ST_HALT: if (resume && !stall)   state_d = ST_RUN;
            ST_TRAP: if (trap_ack && !stall) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        case (state_q)
            ST_RUN: begin
                if (!stall && !is_halt) begin
                    if (taken && misaligned) begin
                        pc_d  = TRAP_VECTOR;
                        epc_d = pc_q;
                    end else if (taken) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            // Resuming steps past the halt instruction rather than re-executing it.
            ST_HALT: if (resume && !stall) pc_d = pc_plus4;
            default: pc_d = pc_q;
        endcase
    end

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign link_addr    = pc_plus4;
    assign halted       = (state_q == ST_HALT);
    assign trap_pending = (state_q == ST_TRAP);

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed scoreboard bench for pc_unit (32-bit and 8-bit instances)
module tb_pc_unit;

    localparam logic [6:0] NOP    = 7'h13;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'h7F;

    logic        clk = 1'b0;
    logic        rst, stall, resume, trap_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] pc, link_addr, epc;
    logic        taken, halted, trap_pending;

    logic        b_rst, b_stall, b_resume, b_trap_ack;
    logic [6:0]  b_opcode;
    logic [2:0]  b_funct3;
    logic [7:0]  b_rs1, b_rs2, b_imm;
    logic [7:0]  b_pc, b_link, b_epc;
    logic        b_taken, b_halted, b_trap;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .resume(resume), .trap_ack(trap_ack),
        .pc(pc), .link_addr(link_addr), .taken(taken), .halted(halted),
        .trap_pending(trap_pending), .epc(epc)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80)) dut8 (
        .clk(clk), .rst(b_rst), .stall(b_stall), .opcode(b_opcode), .funct3(b_funct3),
        .rs1_val(b_rs1), .rs2_val(b_rs2), .imm(b_imm), .resume(b_resume), .trap_ack(b_trap_ack),
        .pc(b_pc), .link_addr(b_link), .taken(b_taken), .halted(b_halted),
        .trap_pending(b_trap), .epc(b_epc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock and compare the selected DUT's pc with the oldest scoreboard entry.
    task automatic cyc(input string tag, input bit narrow);
        logic [31:0] e;
        tick();
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, narrow ? {24'h0, b_pc} : pc, e);
        end
    endtask

    task automatic step_pc(input string tag, input logic [31:0] nxt);
        exp_q.push_back(nxt);
        cyc(tag, 1'b0);
        exp_pc = nxt;
    endtask

    task automatic goto_pc(input logic [31:0] tgt);
        opcode = JAL;
        imm    = tgt - exp_pc;
        #1;
        chk("jal_link", link_addr, exp_pc + 32'd4);
        chk("jal_taken", {31'h0, taken}, 32'd1);
        step_pc("jal_pc", tgt);
        opcode = NOP;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        tk;
    } br_t;

    br_t br_tab[12];

    initial begin
        br_tab[0]  = '{3'b000, 32'd5,        32'd5,        1'b1};
        br_tab[1]  = '{3'b000, 32'd5,        32'd6,        1'b0};
        br_tab[2]  = '{3'b001, 32'd5,        32'd6,        1'b1};
        br_tab[3]  = '{3'b001, 32'd7,        32'd7,        1'b0};
        br_tab[4]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        1'b1};
        br_tab[5]  = '{3'b101, 32'hFFFFFFFF, 32'd1,        1'b0};
        br_tab[6]  = '{3'b101, 32'd1,        32'd1,        1'b1};
        br_tab[7]  = '{3'b110, 32'hFFFFFFFF, 32'd1,        1'b0};
        br_tab[8]  = '{3'b110, 32'd1,        32'hFFFFFFFF, 1'b1};
        br_tab[9]  = '{3'b111, 32'hFFFFFFFF, 32'd1,        1'b1};
        br_tab[10] = '{3'b010, 32'd0,        32'd0,        1'b0};
        br_tab[11] = '{3'b011, 32'd5,        32'd5,        1'b0};

        rst = 1'b0; stall = 1'b0; resume = 1'b0; trap_ack = 1'b0;
        opcode = NOP; funct3 = 3'b000; rs1_val = '0; rs2_val = '0; imm = '0;
        b_rst = 1'b0; b_stall = 1'b0; b_resume = 1'b0; b_trap_ack = 1'b0;
        b_opcode = NOP; b_funct3 = 3'b000; b_rs1 = '0; b_rs2 = '0; b_imm = '0;
        tick();
        tick();

        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_trap", {31'h0, trap_pending}, 32'd0);
        chk("rst_taken", {31'h0, taken}, 32'd0);
        exp_pc = 32'h0;

        rst = 1'b1;
        step_pc("nop1", 32'h4);
        step_pc("nop2", 32'h8);
        step_pc("nop3", 32'hC);
        chk("run_halted", {31'h0, halted}, 32'd0);
        chk("run_trap", {31'h0, trap_pending}, 32'd0);
        step_pc("nop4", 32'h10);

        opcode = BRANCH; funct3 = 3'b100; rs1_val = 32'hFFFFFFFF; rs2_val = 32'd1; imm = 32'h20;
        #1;
        chk("blt_taken", {31'h0, taken}, 32'd1);
        step_pc("blt_pc", 32'h30);

        // Not-taken branch whose target is misaligned must fall through, not trap.
        funct3 = 3'b110; imm = 32'h22;
        #1;
        chk("bltu_taken", {31'h0, taken}, 32'd0);
        step_pc("bltu_pc", 32'h34);
        chk("bltu_notrap", {31'h0, trap_pending}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            opcode = BRANCH; funct3 = br_tab[i].f3;
            rs1_val = br_tab[i].a; rs2_val = br_tab[i].b; imm = 32'h8;
            #1;
            chk($sformatf("br%0d_taken", i), {31'h0, taken}, {31'h0, br_tab[i].tk});
            step_pc($sformatf("br%0d_pc", i), br_tab[i].tk ? exp_pc + 32'h8 : exp_pc + 32'h4);
        end
        opcode = NOP;

        goto_pc(32'h40);
        opcode = JALR; rs1_val = 32'h103; imm = 32'h4;
        #1;
        chk("jalr_taken", {31'h0, taken}, 32'd1);
        step_pc("jalr_trap_pc", 32'h100);
        chk("trap_epc", epc, 32'h40);
        chk("trap_pending", {31'h0, trap_pending}, 32'd1);
        opcode = JAL; imm = 32'h8; resume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("trap_hold_taken", {31'h0, taken}, 32'd0);
            step_pc("trap_hold_pc", 32'h100);
        end
        resume = 1'b0; opcode = NOP;
        trap_ack = 1'b1; stall = 1'b1;
        step_pc("trap_ack_stalled", 32'h100);
        chk("trap_still", {31'h0, trap_pending}, 32'd1);
        stall = 1'b0;
        step_pc("trap_ack_pc", 32'h100);
        chk("trap_left", {31'h0, trap_pending}, 32'd0);
        trap_ack = 1'b0;
        step_pc("after_trap", 32'h104);

        goto_pc(32'h20);
        opcode = HALT;
        step_pc("halt_pc", 32'h20);
        chk("halted", {31'h0, halted}, 32'd1);
        opcode = JAL; imm = 32'h40;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("halt_taken", {31'h0, taken}, 32'd0);
            step_pc("halt_hold", 32'h20);
        end
        opcode = NOP; resume = 1'b1; stall = 1'b1;
        step_pc("resume_stalled", 32'h20);
        chk("halt_still", {31'h0, halted}, 32'd1);
        stall = 1'b0;
        step_pc("resume_pc", 32'h24);
        chk("resumed", {31'h0, halted}, 32'd0);
        resume = 1'b0;
        chk("epc_stable", epc, 32'h40);

        opcode = BRANCH; funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; imm = 32'h10; stall = 1'b1;
        #1;
        chk("stall_taken", {31'h0, taken}, 32'd0);
        step_pc("stall_pc", 32'h24);
        stall = 1'b0;
        #1;
        chk("unstall_taken", {31'h0, taken}, 32'd1);
        step_pc("unstall_pc", 32'h34);

        // Reset while trapped must clear pc, epc and state.
        opcode = JAL; imm = 32'h2;
        step_pc("trap2_pc", 32'h100);
        chk("trap2_pending", {31'h0, trap_pending}, 32'd1);
        rst = 1'b0; opcode = NOP;
        step_pc("rst_trap_pc", 32'h0);
        chk("rst_trap_state", {31'h0, trap_pending}, 32'd0);
        chk("rst_trap_epc", epc, 32'h0);
        rst = 1'b1;

        b_rst = 1'b1; b_opcode = JAL; b_imm = 8'hFC;
        exp_q.push_back(32'hFC);
        cyc("w8_jal", 1'b1);
        b_opcode = NOP;
        #1;
        chk("w8_link_wrap", {24'h0, b_link}, 32'h00);
        exp_q.push_back(32'h00);
        cyc("w8_wrap", 1'b1);
        b_opcode = HALT;
        exp_q.push_back(32'h00);
        cyc("w8_halt", 1'b1);
        chk("w8_halted", {31'h0, b_halted}, 32'd1);
        b_opcode = NOP; b_rst = 1'b0;
        exp_q.push_back(32'h00);
        cyc("w8_rst_pc", 1'b1);
        chk("w8_rst_halted", {31'h0, b_halted}, 32'd0);
        b_rst = 1'b1;
        exp_q.push_back(32'h04);
        cyc("w8_run", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
